// File: rtl/slave_rd_arbiter.sv
// Two-master read arbiter: per-master request FIFOs, round-robin grant, single outstanding slave read.
// Latency: s_req rises 2 edges after a push into an empty FIFO; ack/resp pulse 1 cycle after slave response.
// Backpressure: mX_fifo_full when FIFO holds FIFO_DEPTH entries; pushes while full are dropped.
// Optional watchdog: define SLAVE_RD_ARB_TIMEOUT_EN to enable the TIMEOUT-cycle slave watchdog.

// Generic synchronous FIFO; push is ignored while full, pop must only be issued when not empty.
module slave_rd_arbiter_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;

  assign wr_en = push && !full;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps count unchanged.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module slave_rd_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              m0_wren,
  input  logic [AWIDTH-1:0] m0_addr,
  output logic              m0_fifo_full,
  output logic              m0_ack,
  output logic              m0_resp,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_wren,
  input  logic [AWIDTH-1:0] m1_addr,
  output logic              m1_fifo_full,
  output logic              m1_ack,
  output logic              m1_resp,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              s_req,
  output logic [AWIDTH-1:0] s_addr,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DWIDTH-1:0] s_rdata,
  output logic              rd_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RETURN} state_t;

  state_t            state, state_n;
  logic [AWIDTH-1:0] head0, head1;
  logic              empty0, empty1;
  logic              pop0, pop1;
  logic              sel;        // 1 selects master 1 in IDLE
  logic              grant_q;    // master currently/last granted; resets to 1 so master 0 wins first
  logic              capture;    // slave response accepted this cycle
  logic              tmo;        // watchdog limit reached in current state
  logic              tmo_hit;    // watchdog forces completion this cycle
  logic [DWIDTH-1:0] ret_data;

  slave_rd_arbiter_fifo #(.WIDTH(AWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .aclk(aclk), .areset(areset), .push(m0_wren), .din(m0_addr), .pop(pop0),
    .dout(head0), .full(m0_fifo_full), .empty(empty0)
  );

  slave_rd_arbiter_fifo #(.WIDTH(AWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .aclk(aclk), .areset(areset), .push(m1_wren), .din(m1_addr), .pop(pop1),
    .dout(head1), .full(m1_fifo_full), .empty(empty1)
  );

  assign s_req    = (state == REQ);
  assign m0_ack   = (state == RETURN) && !grant_q;
  assign m0_resp  = (state == RETURN) && !grant_q;
  assign m1_ack   = (state == RETURN) && grant_q;
  assign m1_resp  = (state == RETURN) && grant_q;
  assign ret_data = capture ? s_rdata : '1;

  // Next-state, round-robin selection and FIFO pop decode.
  always_comb begin
    state_n = state;
    pop0    = 1'b0;
    pop1    = 1'b0;
    capture = 1'b0;
    tmo_hit = 1'b0;
    sel     = (!empty0 && !empty1) ? !grant_q : empty0;
    case (state)
      IDLE: begin
        if (!empty0 || !empty1) begin
          state_n = REQ;
          pop0    = !sel;
          pop1    = sel;
        end
      end
      REQ: begin
        if (s_ack && s_resp) begin
          state_n = RETURN;
          capture = 1'b1;
        end else if (s_ack) begin
          state_n = WAIT_RESP;
        end else if (tmo) begin
          state_n = RETURN;
          tmo_hit = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (s_resp) begin
          state_n = RETURN;
          capture = 1'b1;
        end else if (tmo) begin
          state_n = RETURN;
          tmo_hit = 1'b1;
        end
      end
      RETURN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, grant pointer, slave address and per-master returned data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      grant_q  <= 1'b1;
      s_addr   <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_n;
      if (pop0 || pop1) begin
        grant_q <= pop1;
        s_addr  <= pop1 ? head1 : head0;
      end
      if (capture || tmo_hit) begin
        if (grant_q) m1_rdata <= ret_data;
        else         m0_rdata <= ret_data;
      end
    end
  end

`ifdef SLAVE_RD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo = ((state == REQ) || (state == WAIT_RESP)) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Watchdog counter restarts on every state change; expiry pulse lines up with RETURN.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tmo_cnt    <= '0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= tmo_hit;
      if (state_n != state)                          tmo_cnt <= '0;
      else if ((state == REQ) || (state == WAIT_RESP)) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign rd_timeout     = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif
endmodule

// File: tb/tb_slave_rd_arbiter.sv
// Bench for slave_rd_arbiter: scoreboard of expected slave addresses and master returns.
// Latency: checks s_req two edges after push and ack/resp one cycle after slave response.
// Backpressure: fills master 0 FIFO, checks full flag and dropped push.
module tb_slave_rd_arbiter;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        m0_wren = 1'b0, m1_wren = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_fifo_full, m1_fifo_full;
  logic        m0_ack, m1_ack, m0_resp, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_ack = 1'b0, s_resp = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        rd_timeout;

  typedef struct { logic m; logic [31:0] d; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_ack0 = 0, cnt_ack1 = 0, cnt_req = 0;
  logic sreq_d = 1'b0;

  always #5 aclk = ~aclk;

  slave_rd_arbiter #(.AWIDTH(32), .DWIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset),
    .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_fifo_full(m0_fifo_full),
    .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
    .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_fifo_full(m1_fifo_full),
    .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
    .rd_timeout(rd_timeout)
  );

  // Scoreboard monitor: slave address on each s_req rise, master id/data on each return pulse.
  always @(negedge aclk) begin
    if (s_req && !sreq_d) begin
      cnt_req++;
      n_checks++;
      if (addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_addr unexpected s_req addr=%h", s_addr);
      end else begin
        logic [31:0] ea;
        ea = addr_q.pop_front();
        if (s_addr !== ea) begin
          n_fail++;
          $display("FAIL sb_addr s_addr=%h expected %h", s_addr, ea);
        end
      end
    end
    sreq_d = s_req;
    if (m0_ack) cnt_ack0++;
    if (m1_ack) cnt_ack1++;
    if (m0_ack || m1_ack || m0_resp || m1_resp) begin
      n_checks++;
      if ((m0_ack && m1_ack) || (m0_ack !== m0_resp) || (m1_ack !== m1_resp)) begin
        n_fail++;
        $display("FAIL sb_pulse ack0=%b resp0=%b ack1=%b resp1=%b expected one master with ack=resp",
                 m0_ack, m0_resp, m1_ack, m1_resp);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_ret unexpected return ack0=%b ack1=%b", m0_ack, m1_ack);
      end else begin
        exp_t e;
        logic [31:0] got;
        e   = exp_q.pop_front();
        got = m1_ack ? m1_rdata : m0_rdata;
        if (m1_ack !== e.m || got !== e.d) begin
          n_fail++;
          $display("FAIL sb_ret master=%b data=%h expected master=%b data=%h", m1_ack, got, e.m, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "stopped");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    idle(2);
    areset = 1'b0;
  endtask

  task automatic drive_push(input logic w0, input logic [31:0] a0, input logic w1, input logic [31:0] a1);
    m0_wren = w0; m0_addr = a0; m1_wren = w1; m1_addr = a1;
    @(posedge aclk); #1;
    m0_wren = 1'b0; m1_wren = 1'b0;
  endtask

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Slave model: accept after ack_dly cycles, respond one cycle later.
  task automatic serve(input logic [31:0] rd, input int ack_dly);
    bit ok;
    wait_sreq(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL serve_wait s_req=0 expected 1 within 100 cycles");
      return;
    end
    repeat (ack_dly) @(negedge aclk);
    s_ack = 1'b1;
    @(posedge aclk); #1;
    s_ack = 1'b0;
    @(negedge aclk);
    s_resp = 1'b1; s_rdata = rd;
    @(posedge aclk); #1;
    s_resp = 1'b0;
    idle(2);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({s_req, m0_ack, m0_resp, m1_ack, m1_resp, m0_fifo_full, m1_fifo_full, rd_timeout} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl outputs=%b expected 00000000",
               {s_req, m0_ack, m0_resp, m1_ack, m1_resp, m0_fifo_full, m1_fifo_full, rd_timeout});
    end
    n_checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || s_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data m0=%h m1=%h s_addr=%h expected 0", m0_rdata, m1_rdata, s_addr);
    end
  endtask

  task automatic test_single();
    int a0, a1;
    a0 = cnt_ack0; a1 = cnt_ack1;
    addr_q.push_back(32'h0000_0010);
    exp_q.push_back('{1'b0, 32'hA5A5_0001});
    drive_push(1'b1, 32'h0000_0010, 1'b0, 32'h0);
    n_checks++;
    if (s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lat1 s_req=%b expected 0 one edge after push", s_req);
    end
    idle(1);
    n_checks++;
    if (s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lat2 s_req=%b expected 1 two edges after push", s_req);
    end
    serve(32'hA5A5_0001, 1);
    idle(3);
    n_checks++;
    if (cnt_ack0 - a0 != 1 || cnt_ack1 != a1) begin
      n_fail++;
      $display("FAIL single_count acks0=%0d acks1=%0d expected 1 and 0", cnt_ack0 - a0, cnt_ack1 - a1);
    end
    n_checks++;
    if (m0_rdata !== 32'hA5A5_0001 || m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL single_hold m0_rdata=%h m1_rdata=%h expected a5a50001 and 0", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    int a0, a1;
    apply_reset();
    a0 = cnt_ack0; a1 = cnt_ack1;
    addr_q.push_back(32'h0000_0010);  exp_q.push_back('{1'b0, 32'hB000_0001});
    addr_q.push_back(32'h8000_0020);  exp_q.push_back('{1'b1, 32'hB000_0002});
    drive_push(1'b1, 32'h0000_0010, 1'b1, 32'h8000_0020);
    serve(32'hB000_0001, 0);
    serve(32'hB000_0002, 0);
    addr_q.push_back(32'h0000_0050);  exp_q.push_back('{1'b0, 32'hB000_0003});
    addr_q.push_back(32'h0000_0030);  exp_q.push_back('{1'b1, 32'hB000_0004});
    addr_q.push_back(32'h0000_0040);  exp_q.push_back('{1'b0, 32'hB000_0005});
    drive_push(1'b1, 32'h0000_0050, 1'b0, 32'h0);
    drive_push(1'b0, 32'h0, 1'b1, 32'h0000_0030);
    drive_push(1'b1, 32'h0000_0040, 1'b0, 32'h0);
    serve(32'hB000_0003, 0);
    serve(32'hB000_0004, 0);
    serve(32'hB000_0005, 0);
    idle(3);
    n_checks++;
    if (cnt_ack0 - a0 != 3 || cnt_ack1 - a1 != 2) begin
      n_fail++;
      $display("FAIL rr_count acks0=%0d acks1=%0d expected 3 and 2", cnt_ack0 - a0, cnt_ack1 - a1);
    end
  endtask

  task automatic test_fifo_full();
    int a0, r0;
    a0 = cnt_ack0; r0 = cnt_req;
    for (int i = 0; i < 5; i++) begin
      addr_q.push_back(32'h100 + 32'(i * 4));
      exp_q.push_back('{1'b0, 32'hC000_0000 + 32'(i)});
      drive_push(1'b1, 32'h100 + 32'(i * 4), 1'b0, 32'h0);
    end
    n_checks++;
    if (m0_fifo_full !== 1'b1 || m1_fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flag m0_full=%b m1_full=%b expected 1 and 0", m0_fifo_full, m1_fifo_full);
    end
    drive_push(1'b1, 32'h0000_1FF0, 1'b0, 32'h0);
    n_checks++;
    if (m0_fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop m0_full=%b expected 1 after dropped push", m0_fifo_full);
    end
    for (int i = 0; i < 5; i++) serve(32'hC000_0000 + 32'(i), 0);
    idle(10);
    n_checks++;
    if (cnt_ack0 - a0 != 5 || cnt_req - r0 != 5 || m0_fifo_full !== 1'b0 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full_returns acks=%0d reqs=%0d full=%b s_req=%b expected 5 5 0 0",
               cnt_ack0 - a0, cnt_req - r0, m0_fifo_full, s_req);
    end
  endtask

  task automatic test_together();
    bit ok;
    int a1;
    a1 = cnt_ack1;
    addr_q.push_back(32'h0000_0200);
    exp_q.push_back('{1'b1, 32'h1234_5678});
    drive_push(1'b0, 32'h0, 1'b1, 32'h0000_0200);
    wait_sreq(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL together_wait s_req=0 expected 1");
    end
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h1234_5678;
    @(posedge aclk); #1;
    s_ack = 1'b0; s_resp = 1'b0;
    n_checks++;
    if (m1_ack !== 1'b1 || m1_resp !== 1'b1 || m1_rdata !== 32'h1234_5678 || m0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL together_ret m1_ack=%b m1_resp=%b m1_rdata=%h m0_ack=%b expected 1 1 12345678 0",
               m1_ack, m1_resp, m1_rdata, m0_ack);
    end
    idle(1);
    n_checks++;
    if (m1_ack !== 1'b0 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL together_once m1_ack=%b s_req=%b expected 0 0", m1_ack, s_req);
    end
    idle(3);
    n_checks++;
    if (cnt_ack1 - a1 != 1) begin
      n_fail++;
      $display("FAIL together_count acks1=%0d expected 1", cnt_ack1 - a1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int a0, a1, r0;
    addr_q.push_back(32'h0000_0300);
    drive_push(1'b1, 32'h0000_0300, 1'b0, 32'h0);
    wait_sreq(ok);
    s_ack = 1'b1;
    @(posedge aclk); #1;
    s_ack = 1'b0;
    drive_push(1'b0, 32'h0, 1'b1, 32'h0000_0310);
    n_checks++;
    if (s_req !== 1'b0 || !ok) begin
      n_fail++;
      $display("FAIL midrst_wait s_req=%b seen=%b expected 0 1 in WAIT_RESP", s_req, ok);
    end
    a0 = cnt_ack0; a1 = cnt_ack1; r0 = cnt_req;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    n_checks++;
    if (s_req !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || m0_fifo_full !== 1'b0 || m1_fifo_full !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out s_req=%b m0_rdata=%h m1_rdata=%h expected all 0", s_req, m0_rdata, m1_rdata);
    end
    @(negedge aclk);
    s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
    @(posedge aclk); #1;
    s_resp = 1'b0;
    idle(10);
    n_checks++;
    if (cnt_ack0 != a0 || cnt_ack1 != a1 || cnt_req != r0) begin
      n_fail++;
      $display("FAIL midrst_late acks0=%0d acks1=%0d reqs=%0d expected 0 0 0",
               cnt_ack0 - a0, cnt_ack1 - a1, cnt_req - r0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    addr_q.push_back(32'h0000_0400);
    drive_push(1'b1, 32'h0000_0400, 1'b0, 32'h0);
    wait_sreq(ok);
`ifdef SLAVE_RD_ARB_TIMEOUT_EN
    begin
      int k;
      exp_q.push_back('{1'b0, 32'hFFFF_FFFF});
      k = 0;
      for (int i = 1; i <= 40; i++) begin
        @(posedge aclk); #1;
        if (rd_timeout) begin
          k = i;
          break;
        end
      end
      n_checks++;
      if (!ok || k != 8) begin
        n_fail++;
        $display("FAIL tmo_latency cycles=%0d expected 8", k);
      end
      n_checks++;
      if (m0_ack !== 1'b1 || m0_resp !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF || s_req !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_ret ack=%b resp=%b rdata=%h s_req=%b expected 1 1 ffffffff 0",
                 m0_ack, m0_resp, m0_rdata, s_req);
      end
      idle(1);
      n_checks++;
      if (rd_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_pulse rd_timeout=%b expected 0 after one cycle", rd_timeout);
      end
    end
`else
    begin
      bit seen;
      seen = 1'b0;
      exp_q.push_back('{1'b0, 32'h600D_0001});
      for (int i = 0; i < 20; i++) begin
        @(posedge aclk); #1;
        if (rd_timeout) seen = 1'b1;
      end
      n_checks++;
      if (!ok || s_req !== 1'b1 || seen) begin
        n_fail++;
        $display("FAIL notmo_wait s_req=%b rd_timeout_seen=%b expected 1 0", s_req, seen);
      end
      serve(32'h600D_0001, 0);
    end
`endif
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_together();
    test_reset_mid();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain pending returns=%0d addrs=%0d expected 0 0", exp_q.size(), addr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
